// File: rtl/scr1_ahb_tcm_slv.sv
// AHB-Lite slave for a single-port TCM SRAM: zero wait states, one stall on read-after-write, hreadyout low only in RD_STALL/ERR1.
// SCR1_AHB_TCM_SLV_ERR_EN: ERROR-respond to bad size/alignment/range instead of normalising them.
module scr1_ahb_tcm_slv #(
  parameter int SCR1_TCM_AWIDTH = 12
) (
  input  logic                       rst_n,
  input  logic                       clk,
  input  logic                       hsel,
  input  logic [1:0]                 htrans,
  input  logic [2:0]                 hsize,
  input  logic                       hwrite,
  input  logic [31:0]                haddr,
  input  logic [31:0]                hwdata,
  input  logic                       hready,
  output logic                       hreadyout,
  output logic [31:0]                hrdata,
  output logic                       hresp,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [3:0]                 mem_be,
  output logic [SCR1_TCM_AWIDTH-1:0] mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_STALL, ERR1, ERR2} state_t;

  state_t                     state, state_nxt;
  logic                       acc, err_n, ld;
  logic [2:0]                 size_n, size_r;
  logic [1:0]                 off_n, off_r;
  logic [SCR1_TCM_AWIDTH-1:0] word_n, addr_r, addr_c;
  logic                       req_c, we_c, rdy_c;
  logic [3:0]                 be_c;
  logic [31:0]                wdata_c;

  function automatic logic [3:0] be_of(input logic [2:0] sz, input logic [1:0] off);
    case (sz)
      3'd0:    be_of = 4'b0001 << off;
      3'd1:    be_of = off[1] ? 4'b1100 : 4'b0011;
      default: be_of = 4'b1111;
    endcase
  endfunction

  assign acc    = hsel & hready & ((htrans == 2'b10) | (htrans == 2'b11));
  assign word_n = SCR1_TCM_AWIDTH'(haddr >> 2);

  // Oversized transfers become words and lanes are aligned down; the error build rejects these first.
  always_comb begin
    size_n = (hsize > 3'd2) ? 3'd2 : hsize;
    off_n  = haddr[1:0];
    case (size_n)
      3'd1:    off_n[0] = 1'b0;
      3'd2:    off_n    = 2'b00;
      default: ;
    endcase
  end

`ifdef SCR1_AHB_TCM_SLV_ERR_EN
  assign err_n = (hsize > 3'd2)
               | ((hsize == 3'd1) & haddr[0])
               | ((hsize == 3'd2) & (haddr[1:0] != 2'b00))
               | (|(haddr >> (SCR1_TCM_AWIDTH + 2)));
`else
  assign err_n = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    req_c     = 1'b0;
    we_c      = 1'b0;
    rdy_c     = 1'b1;
    addr_c    = addr_r;
    be_c      = be_of(size_r, off_r);
    wdata_c   = '0;

    case (state)
      WR: begin
        req_c   = 1'b1;
        we_c    = 1'b1;
        wdata_c = hwdata;
      end
      RD_STALL: begin
        req_c = 1'b1;
        rdy_c = 1'b0;
      end
      ERR1:    rdy_c = 1'b0;
      default: ;
    endcase

    case (state)
      RD_STALL: state_nxt = RD;
      ERR1:     state_nxt = ERR2;
      default: begin
        state_nxt = IDLE;
        if (acc) begin
          ld = 1'b1;
          if (err_n) begin
            state_nxt = ERR1;
          end else if (hwrite) begin
            state_nxt = WR;
          end else if (state == WR) begin
            // SRAM port is busy with the write this cycle; replay the read next cycle.
            state_nxt = RD_STALL;
          end else begin
            state_nxt = RD;
            req_c     = 1'b1;
            addr_c    = word_n;
            be_c      = be_of(size_n, off_n);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_r <= '0;
      size_r <= '0;
      off_r  <= '0;
    end else if (ld) begin
      addr_r <= word_n;
      size_r <= size_n;
      off_r  <= off_n;
    end
  end

  // Outputs are forced to reset values while rst_n is low so an interrupted write never reaches the SRAM.
  assign mem_req   = rst_n & req_c;
  assign mem_we    = rst_n & we_c;
  assign mem_be    = mem_req ? be_c : 4'b0000;
  assign mem_addr  = addr_c;
  assign mem_wdata = wdata_c;
  assign hreadyout = ~rst_n | rdy_c;
  assign hrdata    = (rst_n && (state == RD)) ? mem_rdata : 32'h0;

`ifdef SCR1_AHB_TCM_SLV_ERR_EN
  assign hresp = rst_n & ((state == ERR1) | (state == ERR2));
`else
  assign hresp = 1'b0;
`endif

endmodule

// File: tb/tb_scr1_ahb_tcm_slv.sv
// Random and directed AHB traffic against a transaction-level memory model for scr1_ahb_tcm_slv.
module tb_scr1_ahb_tcm_slv;
  localparam int          AW   = 12;
  localparam int unsigned MEMB = 1 << (AW + 2);
`ifdef SCR1_AHB_TCM_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, hsel = 1'b0, hwrite = 1'b0, load = 1'b1;
  logic [1:0]    htrans = 2'b00;
  logic [2:0]    hsize = 3'd0;
  logic [31:0]   haddr = '0, hwdata = '0;
  logic          hready, hreadyout, hresp, mem_req, mem_we;
  logic [31:0]   hrdata, mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;

  assign hready = hreadyout;
  always #5 clk = ~clk;

  scr1_ahb_tcm_slv #(.SCR1_TCM_AWIDTH(AW)) dut (
    .rst_n(rst_n), .clk(clk), .hsel(hsel), .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hrdata(hrdata),
    .hresp(hresp), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  // SRAM: one-cycle read latency, byte-masked writes.
  logic [31:0] sram [1 << AW];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < (1 << AW); i++) sram[i] <= init_word(i);
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // Reference model: memory image updated by completed transfers in bus order.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          gap;
  } txn_t;

  logic [31:0] ref_mem [1 << AW];
  txn_t        txq[$];
  txn_t        dp;
  bit          dp_v = 1'b0, dp_err = 1'b0, dp_stall = 1'b0, ap_drv = 1'b0;
  int          dp_cyc = 0;
  logic [31:0] last_rd = '0;
  logic        last_resp = 1'b0;
  logic [3:0]  last_be = '0;
  logic [AW-1:0] last_waddr = '0;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int unsigned eff_bytes(input logic [2:0] s);
    return (s > 3'd2) ? 4 : (1 << s);
  endfunction

  function automatic logic [31:0] eff_addr(input txn_t t);
    logic [31:0] a = t.addr % MEMB;
    return a - (a % eff_bytes(t.size));
  endfunction

  function automatic logic [AW-1:0] word_of(input txn_t t);
    return AW'(eff_addr(t) / 4);
  endfunction

  function automatic logic [3:0] exp_be(input txn_t t);
    return 4'(((32'd1 << eff_bytes(t.size)) - 1) << (eff_addr(t) % 4));
  endfunction

  function automatic bit is_err(input txn_t t);
    bit mis = ((t.size == 3'd1) && t.addr[0]) || ((t.size == 3'd2) && (t.addr[1:0] != 2'b00));
    return ERR_EN && ((t.size > 3'd2) || mis || (t.addr >= MEMB));
  endfunction

  task automatic push(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input int gap);
    txn_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata; t.gap = gap;
    txq.push_back(t);
  endtask

  // One bus cycle: entered and left 1 time unit after a rising edge.
  task automatic step();
    bit   acc, exp_wr, rd_ap, rd_st, done;
    txn_t h;
    ap_drv = 1'b0;
    if (txq.size() > 0 && txq[0].gap == 0) begin
      ap_drv = 1'b1;
      hsel = 1'b1; htrans = 2'b10; hwrite = txq[0].wr; hsize = txq[0].size; haddr = txq[0].addr;
    end else begin
      if (txq.size() > 0) begin h = txq[0]; h.gap--; txq[0] = h; end
      case ($urandom_range(0, 2))
        0:       begin hsel = 1'b0; htrans = 2'b10; end
        1:       begin hsel = 1'b1; htrans = 2'b01; end
        default: begin hsel = 1'b1; htrans = 2'b00; end
      endcase
      hwrite = 1'($urandom); hsize = 3'd2; haddr = 32'($urandom_range(0, 255));
    end
    hwdata = (dp_v && dp.wr) ? dp.wdata : $urandom;

    @(negedge clk);
    acc    = ap_drv && (hreadyout === 1'b1);
    exp_wr = dp_v && dp.wr && !dp_err;
    rd_ap  = acc && !txq[0].wr && !is_err(txq[0]) && !exp_wr;
    rd_st  = dp_v && !dp.wr && dp_stall && (dp_cyc == 0);
    chk("mem_req", 32'(mem_req), 32'(exp_wr | rd_ap | rd_st));
    chk("mem_we", 32'(mem_we), 32'(exp_wr));
    if (exp_wr) begin
      chk("wr_addr", 32'(mem_addr), 32'(word_of(dp)));
      chk("wr_be", 32'(mem_be), 32'(exp_be(dp)));
      chk("wr_data", mem_wdata, dp.wdata);
      last_be = mem_be; last_waddr = mem_addr;
    end
    if (rd_ap) chk("rd_addr", 32'(mem_addr), 32'(word_of(txq[0])));
    if (rd_st) chk("stall_addr", 32'(mem_addr), 32'(word_of(dp)));

    if (!dp_v) begin
      chk("idle_rdy", 32'(hreadyout), 32'd1);
      chk("idle_resp", 32'(hresp), 32'd0);
      chk("idle_rdata", hrdata, 32'h0);
    end else begin
      done = dp_cyc >= ((dp_err || dp_stall) ? 1 : 0);
      chk("hreadyout", 32'(hreadyout), 32'(done));
      chk("hresp", 32'(hresp), 32'(dp_err));
      if (done) begin
        if (dp.wr || dp_err) chk("rdata_zero", hrdata, 32'h0);
        else                 chk("rdata", hrdata, ref_mem[word_of(dp)]);
        if (!dp.wr) begin last_rd = hrdata; last_resp = hresp; end
        if (dp.wr && !dp_err)
          for (int b = 0; b < 4; b++)
            if (exp_be(dp)[b]) ref_mem[word_of(dp)][8*b +: 8] = dp.wdata[8*b +: 8];
      end
    end

    if (dp_v && hreadyout === 1'b1) dp_v = 1'b0;
    else if (dp_v)                  dp_cyc++;
    if (acc) begin
      dp       = txq.pop_front();
      dp_v     = 1'b1;
      dp_cyc   = 0;
      dp_err   = is_err(dp);
      dp_stall = !dp.wr && !dp_err && exp_wr;
    end
    @(posedge clk); #1;
  endtask

  task automatic run();
    int guard = 0;
    while ((txq.size() > 0 || dp_v) && guard < 5000) begin
      step();
      guard++;
    end
    if (guard >= 5000) begin
      chk("timeout_pending", 32'(txq.size()) + 32'(dp_v), 32'd0);
      txq.delete();
      dp_v = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"}, 32'(hreadyout), 32'd1);
    chk({tag, "_resp"}, 32'(hresp), 32'd0);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_rdata"}, hrdata, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    repeat (2) begin
      @(negedge clk);
      chk_reset_outputs("reset");
    end
    @(posedge clk); #1;
    load  = 1'b0;
    rst_n = 1'b1;

    // Word write then back-to-back read of the same word.
    push(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1);
    push(1'b0, 32'h10, 3'd2, 32'h0, 0);
    run();
    chk("raw_data", last_rd, 32'hDEADBEEF);
    chk("raw_resp", 32'(last_resp), 32'd0);

    // Byte write to the top lane, then word read.
    push(1'b1, 32'h13, 3'd0, 32'hA5A5A5A5, 2);
    push(1'b0, 32'h10, 3'd2, 32'h0, 2);
    run();
    chk("byte_be", 32'(last_be), 32'h8);
    chk("byte_addr", 32'(last_waddr), 32'd4);
    chk("byte_rd", last_rd, 32'hA5ADBEEF);

    // Idle-separated reads.
    push(1'b0, 32'h0, 3'd2, 32'h0, 2);
    push(1'b0, 32'h4, 3'd2, 32'h0, 2);
    run();
    chk("idle_rd4", last_rd, init_word(1));

    // Misaligned halfword read.
    push(1'b0, 32'h11, 3'd1, 32'h0, 2);
    run();
`ifdef SCR1_AHB_TCM_SLV_ERR_EN
    chk("hw_mis_resp", 32'(last_resp), 32'd1);
`else
    chk("hw_mis_rd", last_rd, 32'hA5ADBEEF);
`endif

    // Long idle/BUSY/deselected stretch before a read.
    push(1'b0, 32'h8, 3'd2, 32'h0, 8);
    run();

    // Reset during the data phase of a write to 0x20.
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h20;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678; rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_wr");
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(1'b0, 32'h20, 3'd2, 32'h0, 1);
    run();
    chk("rst_old", last_rd, init_word(8));

    // Random traffic on a small window to force read-after-write hazards.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom << (AW + 2));
      push(1'($urandom), a, 3'($urandom_range(0, 3)), $urandom,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end
    run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
